strobe_gen: RTL



---
 rtl/strobe_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/strobe_gen.sv
// strobe_gen: programmable single-cycle enable-strobe generator feeding a downstream counter's en.
// Latency: start sampled at edge T -> busy from T+1, first en at T+P, later strobes every P cycles.
// Backpressure: cfg_ready drops while a run is active (offers are held off); start/stop are level commands.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready        configuration handshake (cfg_ready = IDLE & !rst, combinational)
//   cfg_period [period_width]  strobe period in cycles, 0 treated as 1
//   cfg_burst  [burst_width]   strobes per run, 0 = continuous until stop
//   start, stop                run control (start acts in IDLE only, stop acts in RUN only, stop wins)
//   en, busy, done             registered strobe, run indicator, finite-burst completion pulse
//   tick_count [burst_width]   only when STROBE_GEN_TICK_COUNT_EN is defined: strobes issued this run
//
// Build option: define STROBE_GEN_TICK_COUNT_EN to expose tick_count; strobe behaviour is unchanged.

module strobe_gen #(
    parameter int period_width = 16,
    parameter int burst_width  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [period_width-1:0] cfg_period,
    input  logic [burst_width-1:0]  cfg_burst,
    input  logic                    start,
    input  logic                    stop,
    output logic                    en,
    output logic                    busy,
    output logic                    done
`ifdef STROBE_GEN_TICK_COUNT_EN
    ,
    output logic [burst_width-1:0]  tick_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [period_width-1:0] P_ZERO = '0;
    localparam logic [period_width-1:0] P_ONE  = period_width'(1);
    localparam logic [burst_width-1:0]  B_ZERO = '0;
    localparam logic [burst_width-1:0]  B_ONE  = burst_width'(1);

    state_t                  state_q, state_d;
    logic [period_width-1:0] period_q, period_d;
    logic [burst_width-1:0]  burst_q, burst_d;
    logic [period_width-1:0] div_q, div_d;
    logic [burst_width-1:0]  ticks_q, ticks_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    cfg_hs;
    logic                    launch;
    logic                    leave_run;
    logic [period_width-1:0] eff_period;
    logic [burst_width-1:0]  eff_burst;
    logic [period_width-1:0] div_step;
    logic [burst_width-1:0]  ticks_inc;

    // ------------------------------------------------------------------
    // Handshake and effective configuration
    // ------------------------------------------------------------------
    assign cfg_ready = (state_q == IDLE) && !rst;
    assign cfg_hs    = cfg_valid && cfg_ready;

    // A handshake in the same cycle as start must steer the run, so the
    // launch path looks through to the offered values rather than the regs.
    assign eff_period = cfg_hs ? ((cfg_period == P_ZERO) ? P_ONE : cfg_period) : period_q;
    assign eff_burst  = cfg_hs ? cfg_burst : burst_q;

    // stop beats start in IDLE.
    assign launch    = (state_q == IDLE) && start && !stop;
    // A finished burst leaves RUN on the cycle its last strobe/done is visible.
    assign leave_run = (state_q == RUN) && (stop || done_q);

    // Divider walk: reload on zero, otherwise count down. A strobe is issued
    // on the edge where the divider arrives at zero, which puts the first
    // strobe P cycles after start and keeps later strobes P apart.
    assign div_step  = (div_q == P_ZERO) ? (period_q - P_ONE) : (div_q - P_ONE);
    assign ticks_inc = ticks_q + B_ONE;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch)    state_d = RUN;
            RUN:     if (leave_run) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        period_d = eff_period;
        burst_d  = eff_burst;
        div_d    = div_q;
        ticks_d  = ticks_q;
        busy_d   = busy_q;
        en_d     = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    div_d   = eff_period - P_ONE;
                    ticks_d = B_ZERO;
                    busy_d  = 1'b1;
                    // Period 1: the divider is already at zero on launch,
                    // so the first strobe goes out straight away.
                    if (eff_period == P_ONE) begin
                        en_d    = 1'b1;
                        ticks_d = B_ONE;
                        done_d  = (eff_burst == B_ONE);
                    end
                end
            end
            RUN: begin
                if (leave_run) begin
                    // stop suppresses any strobe due at this edge; after a
                    // completed burst nothing further may be issued either.
                    busy_d = 1'b0;
                end else begin
                    div_d = div_step;
                    if (div_step == P_ZERO) begin
                        en_d    = 1'b1;
                        ticks_d = ticks_inc;  // wraps freely in continuous mode
                        done_d  = (burst_q != B_ZERO) && (ticks_inc == burst_q);
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= P_ONE;
            burst_q  <= B_ZERO;
            div_q    <= P_ZERO;
            ticks_q  <= B_ZERO;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            burst_q  <= burst_d;
            div_q    <= div_d;
            ticks_q  <= ticks_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef STROBE_GEN_TICK_COUNT_EN
    // ticks_q is itself a register; it clears on launch and holds in IDLE.
    assign tick_count = ticks_q;
`endif

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_en_in_run: assert property (@(posedge clk) disable iff (rst) en_q |-> busy_q);
    a_done_with_en: assert property (@(posedge clk) disable iff (rst) done_q |-> en_q);
    a_period_nonzero: assert property (@(posedge clk) disable iff (rst) period_q != P_ZERO);

endmodule
